// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR2 MIG request arbiter: state encoding,
// MIG command codes, write-mask constants and the byte-to-MIG address map.
package ddr_arb_pkg;

    localparam int BEAT_W = 128;
    localparam int LINE_W = 2 * BEAT_W;
    localparam int MASK_W = BEAT_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CMD   = 3'd1,
        ST_RD_BEAT0 = 3'd2,
        ST_RD_BEAT1 = 3'd3,
        ST_WR_BEAT0 = 3'd4,
        ST_WR_BEAT1 = 3'd5,
        ST_WR_CMD   = 3'd6,
        ST_DONE     = 3'd7
    } arb_state_e;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;

    localparam logic [MASK_W-1:0] MASK_NONE = 16'h0000;
    localparam logic [MASK_W-1:0] MASK_ALL  = 16'hFFFF;

    // Line index (byte address bits [29:5]) to the 31-bit MIG address.
    function automatic logic [30:0] mig_addr(input logic [24:0] line_idx);
        return {4'b0000, line_idx, 2'b00};
    endfunction

endpackage

// File: rtl/ddr_arb_grant.sv
// Winner selection between icache and dcache requests.
// Optional macro ARB_ROUND_ROBIN_EN: ties are broken by a last-grant
// pointer; without it dcache always wins a tie.
module ddr_arb_grant (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic cpu_clk_g,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic ic_req,
    input  logic dc_req,
    output logic gnt_valid,
    output logic gnt_dc
);

    assign gnt_valid = ic_req | dc_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dc;

    // Remember who was served last; reset value means icache went last.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            last_dc <= 1'b0;
        end else if (grant_en && gnt_valid) begin
            last_dc <= gnt_dc;
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        gnt_dc = dc_req && (!ic_req || !last_dc);
    end
`else
    // Fixed priority: dcache over icache.
    always_comb begin
        gnt_dc = dc_req;
    end
`endif

endmodule

// File: rtl/ddr_req_arbiter.sv
// Shares one DDR2 MIG port between icache fills, dcache fills and dcache
// write-through stores, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for init_done and a request; grant and latch
// RD_CMD   | push read command when the address FIFO has room
// RD_BEAT0 | wait for first read beat (line bits 127:0)
// RD_BEAT1 | wait for second read beat, then write the line out
// WR_BEAT0 | push store beat with requester mask
// WR_BEAT1 | push fully masked filler beat
// WR_CMD   | push write command after both data beats
// DONE     | one-cycle done pulse to the served requester
module ddr_req_arbiter
    import ddr_arb_pkg::*;
(
    input  logic                cpu_clk_g,
    input  logic                rst,
    input  logic                ic_req,
    input  logic [31:0]         ic_addr,
    output logic                ic_done,
    output logic [LINE_W-1:0]   ic_line,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [31:0]         dc_addr,
    input  logic [BEAT_W-1:0]   dc_wdata,
    input  logic [MASK_W-1:0]   dc_wmask,
    output logic                dc_done,
    output logic [LINE_W-1:0]   dc_line,
    output logic [2:0]          af_cmd_din,
    output logic [30:0]         af_addr_din,
    output logic                af_wr_en,
    input  logic                af_full,
    output logic [BEAT_W-1:0]   wdf_din,
    output logic [MASK_W-1:0]   wdf_mask_din,
    output logic                wdf_wr_en,
    input  logic                wdf_full,
    input  logic [BEAT_W-1:0]   rdf_dout,
    input  logic                rdf_valid,
    input  logic                init_done
);

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic                arb_en;
    logic                gnt_valid;
    logic                gnt_dc;
    logic                grant_fire;
    logic                sel_dc;
    logic [30:0]         af_addr_r;
    logic [BEAT_W-1:0]   wdata_r;
    logic [MASK_W-1:0]   wmask_r;
    logic [BEAT_W-1:0]   beat0_r;
    logic                unused_addr_bits;

    // Only the 32-byte line index reaches the MIG.
    assign unused_addr_bits = ^{ic_addr[31:30], ic_addr[4:0],
                                dc_addr[31:30], dc_addr[4:0]};

    assign arb_en = (state == ST_IDLE) && init_done;

    ddr_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .cpu_clk_g (cpu_clk_g),
        .rst       (rst),
        .grant_en  (arb_en),
`endif
        .ic_req    (ic_req),
        .dc_req    (dc_req),
        .gnt_valid (gnt_valid),
        .gnt_dc    (gnt_dc)
    );

    // State register.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transaction latch at grant, read-beat capture and line write-out.
    // Beat 0 is staged so a line register only changes when the whole
    // fill is in, keeping the previous line stable during a refill.
    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            sel_dc    <= 1'b0;
            af_addr_r <= '0;
            wdata_r   <= '0;
            wmask_r   <= MASK_NONE;
            beat0_r   <= '0;
            ic_line   <= '0;
            dc_line   <= '0;
        end else begin
            if (grant_fire) begin
                sel_dc    <= gnt_dc;
                af_addr_r <= mig_addr(gnt_dc ? dc_addr[29:5] : ic_addr[29:5]);
                if (gnt_dc && dc_we) begin
                    wdata_r <= dc_wdata;
                    wmask_r <= dc_wmask;
                end
            end
            if (state == ST_RD_BEAT0 && rdf_valid) begin
                beat0_r <= rdf_dout;
            end
            if (state == ST_RD_BEAT1 && rdf_valid) begin
                if (sel_dc) begin
                    dc_line <= {rdf_dout, beat0_r};
                end else begin
                    ic_line <= {rdf_dout, beat0_r};
                end
            end
        end
    end

    // Next state and MIG/requester strobes; data buses read zero when idle.
    always_comb begin
        state_nxt    = state;
        grant_fire   = 1'b0;
        af_wr_en     = 1'b0;
        af_cmd_din   = CMD_WRITE;
        af_addr_din  = '0;
        wdf_wr_en    = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = MASK_NONE;
        ic_done      = 1'b0;
        dc_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_en && gnt_valid) begin
                    grant_fire = 1'b1;
                    state_nxt  = (gnt_dc && dc_we) ? ST_WR_BEAT0 : ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                if (!af_full) begin
                    af_wr_en    = 1'b1;
                    af_cmd_din  = CMD_READ;
                    af_addr_din = af_addr_r;
                    state_nxt   = ST_RD_BEAT0;
                end
            end
            ST_RD_BEAT0: begin
                if (rdf_valid) begin
                    state_nxt = ST_RD_BEAT1;
                end
            end
            ST_RD_BEAT1: begin
                if (rdf_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WR_BEAT0: begin
                if (!wdf_full) begin
                    wdf_wr_en    = 1'b1;
                    wdf_din      = wdata_r;
                    wdf_mask_din = wmask_r;
                    state_nxt    = ST_WR_BEAT1;
                end
            end
            ST_WR_BEAT1: begin
                if (!wdf_full) begin
                    wdf_wr_en    = 1'b1;
                    wdf_din      = '0;
                    wdf_mask_din = MASK_ALL;
                    state_nxt    = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                if (!af_full) begin
                    af_wr_en    = 1'b1;
                    af_cmd_din  = CMD_WRITE;
                    af_addr_din = af_addr_r;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                ic_done   = !sel_dc;
                dc_done   = sel_dc;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter with a transaction-level expectation
// model (queues of expected MIG pushes and done events) and a MIG read
// responder.
module tb_ddr_req_arbiter;

    localparam int MIG_LAT = 2;

    logic         cpu_clk_g = 1'b0;
    logic         rst;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_done;
    logic [255:0] ic_line;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic [15:0]  dc_wmask;
    logic         dc_done;
    logic [255:0] dc_line;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic         af_full;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         wdf_full;
    logic [127:0] rdf_dout;
    logic         rdf_valid;
    logic         init_done;

    always #5 cpu_clk_g = ~cpu_clk_g;

    ddr_req_arbiter dut (
        .cpu_clk_g    (cpu_clk_g),
        .rst          (rst),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_done      (ic_done),
        .ic_line      (ic_line),
        .dc_req       (dc_req),
        .dc_we        (dc_we),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_wmask     (dc_wmask),
        .dc_done      (dc_done),
        .dc_line      (dc_line),
        .af_cmd_din   (af_cmd_din),
        .af_addr_din  (af_addr_din),
        .af_wr_en     (af_wr_en),
        .af_full      (af_full),
        .wdf_din      (wdf_din),
        .wdf_mask_din (wdf_mask_din),
        .wdf_wr_en    (wdf_wr_en),
        .wdf_full     (wdf_full),
        .rdf_dout     (rdf_dout),
        .rdf_valid    (rdf_valid),
        .init_done    (init_done)
    );

    int total = 0;
    int bad   = 0;

    // expectation model
    logic [33:0]  exp_af[$];     // {cmd, addr}
    logic [143:0] exp_wdf[$];    // {data, mask}
    logic [257:0] exp_done[$];   // {is_dc, is_read, line}
    logic [255:0] rd_beats[$];   // {beat1, beat0} for the responder
    logic [143:0] wdf_log[$];
    logic [255:0] mdl_ic;
    logic [255:0] mdl_dc;
    bit           mdl_last_dc;
    logic [33:0]  last_af;
    bit           mon_en = 0;
    bit           mig_half = 0;
    int           n1, n2;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Byte address to MIG address, by arithmetic on the 32-byte line number.
    function automatic logic [30:0] m_map(input logic [31:0] a);
        logic [31:0] line_no;
        line_no = (a % 32'h4000_0000) / 32;
        return 31'(line_no * 4);
    endfunction

    // Who wins when the given requesters are pending.
    function automatic bit m_pick_dc(input bit ic, input bit dc);
        if (!ic) return 1'b1;
        if (!dc) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        return !mdl_last_dc;
`else
        return 1'b1;
`endif
    endfunction

    task automatic expect_read(input bit is_dc, input logic [31:0] a,
                               input logic [127:0] b0, input logic [127:0] b1);
        exp_af.push_back({3'b001, m_map(a)});
        rd_beats.push_back({b1, b0});
        exp_done.push_back({is_dc, 1'b1, b1, b0});
        mdl_last_dc = is_dc;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [127:0] d,
                                input logic [15:0] m);
        exp_wdf.push_back({d, m});
        exp_wdf.push_back({128'h0, 16'hFFFF});
        exp_af.push_back({3'b000, m_map(a)});
        exp_done.push_back({1'b1, 1'b0, 256'h0});
        mdl_last_dc = 1'b1;
    endtask

    task automatic tick();
        @(posedge cpu_clk_g);
        #1;
    endtask

    // Counts cycles until the requester's done is seen, then steps into
    // the following cycle.
    task automatic wait_done(input bit want_dc, input int max, output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < max) begin
            @(negedge cpu_clk_g);
            if (want_dc ? dc_done : ic_done) seen = 1;
            else begin
                @(posedge cpu_clk_g);
                #1;
                n++;
            end
        end
        chk(want_dc ? "dc_done_timeout" : "ic_done_timeout", seen, 1);
        tick();
    endtask

    // MIG read side: returns the two beats MIG_LAT cycles after a read push.
    initial begin
        logic [255:0] b;
        rdf_valid = 1'b0;
        rdf_dout  = '0;
        forever begin
            @(negedge cpu_clk_g);
            if (af_wr_en && !af_full && af_cmd_din == 3'b001) begin
                b = (rd_beats.size() > 0) ? rd_beats.pop_front() : 256'h0;
                repeat (MIG_LAT) @(posedge cpu_clk_g);
                #1;
                rdf_valid = 1'b1;
                rdf_dout  = b[127:0];
                tick();
                if (mig_half) begin
                    rdf_valid = 1'b0;
                end else begin
                    rdf_dout = b[255:128];
                    tick();
                    rdf_valid = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle, check pushes and done pulses against
    // the expectation queues and the line outputs against the model.
    always @(negedge cpu_clk_g) begin
        logic [33:0]  e_af;
        logic [143:0] e_wdf;
        logic [257:0] e_dn;
        if (mon_en) begin
            if (af_wr_en) begin
                chk("af_push_while_full", af_full, 0);
                chk("af_push_expected", exp_af.size() != 0, 1);
                if (exp_af.size() != 0) begin
                    e_af = exp_af.pop_front();
                    chk("af_cmd", af_cmd_din, e_af[33:31]);
                    chk("af_addr", af_addr_din, e_af[30:0]);
                    if (af_cmd_din == 3'b000) chk("wr_data_before_cmd", exp_wdf.size(), 0);
                end
                last_af = {af_cmd_din, af_addr_din};
            end
            if (wdf_wr_en) begin
                chk("wdf_push_while_full", wdf_full, 0);
                chk("wdf_push_expected", exp_wdf.size() != 0, 1);
                if (exp_wdf.size() != 0) begin
                    e_wdf = exp_wdf.pop_front();
                    chk("wdf_beat", {wdf_din, wdf_mask_din}, e_wdf);
                end
                wdf_log.push_back({wdf_din, wdf_mask_din});
            end
            if (ic_done || dc_done) begin
                chk("done_both", ic_done & dc_done, 0);
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) begin
                    e_dn = exp_done.pop_front();
                    chk("done_who", dc_done, e_dn[257]);
                    if (e_dn[256]) begin
                        if (e_dn[257]) mdl_dc = e_dn[255:0];
                        else           mdl_ic = e_dn[255:0];
                    end
                end
            end
            chk("ic_line", ic_line, mdl_ic);
            chk("dc_line", dc_line, mdl_dc);
        end
    end

    initial begin
        rst = 1'b1; init_done = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0; dc_wmask = '0;
        af_full = 1'b0; wdf_full = 1'b0;
        mdl_ic = '0; mdl_dc = '0; mdl_last_dc = 1'b0; last_af = '0;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1;
        chk("reset_outputs",
            {af_wr_en, af_cmd_din, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, ic_done, dc_done}, 0);
        chk("reset_lines", {ic_line, dc_line} != 0, 0);

        // icache fill, held off by init_done
        ic_addr = 32'h0000_0040;
        expect_read(1'b0, ic_addr, {4{32'hAAAA_AAAA}}, {4{32'hBBBB_BBBB}});
        ic_req = 1'b1;
        repeat (4) tick();
        chk("no_grant_before_init", exp_af.size(), 1);
        init_done = 1'b1;
        wait_done(1'b0, 30, n1);
        ic_req = 1'b0;
        chk("rd_latency", n1, 5);
        chk("rd_af_cmd_addr", last_af, {3'b001, 31'h0000_0008});
        chk("rd_line_literal", ic_line, {{4{32'hBBBB_BBBB}}, {4{32'hAAAA_AAAA}}});
        tick();

        // dcache write-through store
        wdf_log.delete();
        dc_we = 1'b1; dc_addr = 32'h0010_0004;
        dc_wdata = 128'h0000_0000_0000_0000_1234_5678_0000_0000;
        dc_wmask = 16'hFF0F;
        expect_write(dc_addr, dc_wdata, dc_wmask);
        dc_req = 1'b1;
        wait_done(1'b1, 30, n1);
        dc_req = 1'b0; dc_we = 1'b0;
        chk("wr_latency", n1, 4);
        chk("wr_af_cmd_addr", last_af, {3'b000, 31'h0002_0000});
        chk("wr_beat_count", wdf_log.size(), 2);
        if (wdf_log.size() == 2) begin
            chk("wr_beat0_literal", wdf_log[0], {128'h0000_0000_0000_0000_1234_5678_0000_0000, 16'hFF0F});
            chk("wr_beat1_literal", wdf_log[1], {128'h0, 16'hFFFF});
        end
        tick();

        // af_full held for the first five RD_CMD cycles
        ic_addr = 32'h0000_1000;
        expect_read(1'b0, ic_addr, {4{32'h1111_0000}}, {4{32'h2222_0000}});
        ic_req = 1'b1; af_full = 1'b1;
        fork
            begin repeat (6) tick(); af_full = 1'b0; end
            wait_done(1'b0, 40, n1);
        join
        ic_req = 1'b0;
        chk("af_full_latency", n1, 10);
        tick();

        // wdf_full between the two write beats
        wdf_log.delete();
        dc_we = 1'b1; dc_addr = 32'h0000_0080;
        dc_wdata = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000;
        dc_wmask = 16'h0FFF;
        expect_write(dc_addr, dc_wdata, dc_wmask);
        dc_req = 1'b1;
        fork
            begin repeat (2) tick(); wdf_full = 1'b1; repeat (3) tick(); wdf_full = 1'b0; end
            wait_done(1'b1, 40, n1);
        join
        dc_req = 1'b0; dc_we = 1'b0;
        chk("wdf_full_latency", n1, 7);
        chk("wdf_full_beats", wdf_log.size(), 2);
        tick();

        // simultaneous reads: winner by the arbitration rule, loser next
        begin
            bit first_dc;
            first_dc = m_pick_dc(1'b1, 1'b1);
            ic_addr = 32'h0000_0300; dc_addr = 32'h0000_0200;
            if (first_dc) begin
                expect_read(1'b1, dc_addr, {4{32'hC1C1_C1C1}}, {4{32'hC2C2_C2C2}});
                expect_read(1'b0, ic_addr, {4{32'hD1D1_D1D1}}, {4{32'hD2D2_D2D2}});
            end else begin
                expect_read(1'b0, ic_addr, {4{32'hD1D1_D1D1}}, {4{32'hD2D2_D2D2}});
                expect_read(1'b1, dc_addr, {4{32'hC1C1_C1C1}}, {4{32'hC2C2_C2C2}});
            end
            ic_req = 1'b1; dc_req = 1'b1;
            fork
                begin wait_done(1'b1, 40, n1); dc_req = 1'b0; end
                begin wait_done(1'b0, 40, n2); ic_req = 1'b0; end
            join
            chk("tie_first_latency", first_dc ? n1 : n2, 5);
            chk("tie_second_latency", first_dc ? n2 : n1, 11);
        end
        tick();

        // reset while waiting for the second read beat
        mig_half = 1;
        ic_addr = 32'h0000_0400;
        exp_af.push_back({3'b001, m_map(ic_addr)});
        rd_beats.push_back({{4{32'h9999_9999}}, {4{32'h8888_8888}}});
        ic_req = 1'b1;
        repeat (4) tick();
        rst = 1'b1; ic_req = 1'b0;
        tick();
        rst = 1'b0;
        mdl_ic = '0; mdl_dc = '0; mdl_last_dc = 1'b0;
        mig_half = 0;
        chk("rst_mid_outputs",
            {af_wr_en, af_cmd_din, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, ic_done, dc_done}, 0);
        chk("rst_mid_lines", {ic_line, dc_line} != 0, 0);
        repeat (4) tick();

        // normal dcache fill after the abort
        dc_addr = 32'h0000_0120;
        expect_read(1'b1, dc_addr, {4{32'h5555_5555}}, {4{32'h6666_6666}});
        dc_req = 1'b1;
        wait_done(1'b1, 30, n1);
        dc_req = 1'b0;
        chk("post_rst_latency", n1, 5);
        chk("post_rst_af", last_af, {3'b001, 31'h0000_0024});
        repeat (3) tick();

        chk("af_left", exp_af.size(), 0);
        chk("wdf_left", exp_wdf.size(), 0);
        chk("done_left", exp_done.size(), 0);
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
